// File: rtl/div_remainder_stage.sv
// Sequential restoring divider for the MDR datapath. It produces one quotient bit per cycle
// and streams the per-iteration flag/msb to the downstream quotation shift stage.
module div_remainder_stage #(
   parameter int DW = 16,
   parameter int CW = $clog2(DW) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [DW-1:0] i_dividend,
   input  logic [DW-1:0] i_divisor,
   output logic          o_ready,
   output logic          o_enable,
   output logic          o_flag,
   output logic          o_msb,
   output logic [DW-1:0] o_quotation,
   output logic [DW-1:0] o_remainder,
   output logic          o_done,
   output logic          o_div_zero
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] d_q;
   logic [DW-1:0] v_q;
   logic [DW-1:0] r_q;
   logic [DW-1:0] q_q;
   logic          zero_q;

   logic [DW:0]   s_ext;
   logic [DW:0]   t_ext;
   logic          flag;

   // The carry-out of the remainder shift is kept in s_ext. A divisor with its MSB set
   // can leave R >= 2^(DW-1), and the subtraction must see that bit.
   always_comb begin
      s_ext = {r_q, d_q[DW-1]};
      t_ext = s_ext - {1'b0, v_q};
      flag  = ~t_ext[DW];
   end

   // NOTE: state registers use non-blocking assignments so every register samples
   // pre-edge values; the datapath registers are reset too, because outputs expose them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         d_q    <= '0;
         v_q    <= '0;
         r_q    <= '0;
         q_q    <= '0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  d_q <= i_dividend;
                  v_q <= i_divisor;
                  cnt <= '0;
                  if (i_divisor == '0) begin
                     q_q    <= '1;
                     r_q    <= i_dividend;
                     zero_q <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     q_q    <= '0;
                     r_q    <= '0;
                     zero_q <= 1'b0;
                     state  <= ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               r_q <= flag ? t_ext[DW-1:0] : s_ext[DW-1:0];
               d_q <= d_q << 1;
               q_q <= {q_q[DW-2:0], flag};
               cnt <= cnt + CW'(1);
               if (cnt == LAST_ITER) state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic in_iter;

   always_comb begin
      in_iter     = (state == ST_ITER);
      o_ready     = (state == ST_IDLE);
      o_done      = (state == ST_DONE);
      o_enable    = in_iter;
      o_flag      = in_iter & flag;
      o_msb       = in_iter & s_ext[DW-1];
      o_div_zero  = o_done & zero_q;
      o_quotation = q_q;
      o_remainder = r_q;
   end

endmodule

// File: tb/tb_div_remainder_stage.sv
// Self-checking bench for div_remainder_stage. It uses directed vectors, hand-written
// handshake/reset sequences and random operands checked against an arithmetic reference.
module tb_div_remainder_stage;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic [DW-1:0] i_dividend;
   logic [DW-1:0] i_divisor;
   logic          o_ready;
   logic          o_enable;
   logic          o_flag;
   logic          o_msb;
   logic [DW-1:0] o_quotation;
   logic [DW-1:0] o_remainder;
   logic          o_done;
   logic          o_div_zero;

   int n_cmp = 0;
   int n_err = 0;

   div_remainder_stage #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_dividend (i_dividend),
      .i_divisor  (i_divisor),
      .o_ready    (o_ready),
      .o_enable   (o_enable),
      .o_flag     (o_flag),
      .o_msb      (o_msb),
      .o_quotation(o_quotation),
      .o_remainder(o_remainder),
      .o_done     (o_done),
      .o_div_zero (o_div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          z;
      logic [DW-1:0] flags;
      int            lat;
      int            en;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division. The flag stream equals the quotient bits MSB first.
   // The msb stream is bit DW-1 of (2*partial_remainder + next dividend bit).
   function automatic void ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [DW-1:0] q, output logic [DW-1:0] r,
                                   output logic [DW-1:0] msbs);
      int ai, bi, rem_prev, s;
      ai   = int'(a);
      bi   = int'(b);
      msbs = '0;
      if (bi == 0) begin
         q = '1;
         r = a;
      end else begin
         q = DW'(ai / bi);
         r = DW'(ai % bi);
         for (int i = 0; i < DW; i++) begin
            rem_prev = (ai >> (DW - i)) % bi;
            s        = 2 * rem_prev + ((ai >> (DW - 1 - i)) & 1);
            msbs[DW-1-i] = s[DW-1];
         end
      end
   endfunction

   task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic ez,
                          input logic [DW-1:0] eflags, input logic [DW-1:0] emsbs,
                          input int elat, input int een, input bit chk_msb);
      logic [DW-1:0] flags, msbs, q_got, r_got;
      logic          z_got, seen;
      int            en_cnt, lat;
      flags  = '0;
      msbs   = '0;
      q_got  = '0;
      r_got  = '0;
      z_got  = 1'b0;
      seen   = 1'b0;
      en_cnt = 0;
      lat    = 0;
      @(negedge clk);
      for (int k = 0; k < 40 && !o_ready; k++) @(negedge clk);
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_enable) begin
            en_cnt++;
            flags = {flags[DW-2:0], o_flag};
            msbs  = {msbs[DW-2:0], o_msb};
         end
         if (o_done) begin
            seen  = 1'b1;
            lat   = k;
            q_got = o_quotation;
            r_got = o_remainder;
            z_got = o_div_zero;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_quot"}, 32'(q_got), 32'(eq));
      check({tag, "_rem"}, 32'(r_got), 32'(er));
      check({tag, "_divzero"}, 32'(z_got), 32'(ez));
      check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(een));
      check({tag, "_flags"}, 32'(flags), 32'(eflags));
      if (chk_msb) check({tag, "_msbs"}, 32'(msbs), 32'(emsbs));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'({o_done, o_div_zero, o_ready}), 32'b001);
      check({tag, "_quot_hold"}, 32'(o_quotation), 32'(eq));
      check({tag, "_rem_hold"}, 32'(o_remainder), 32'(er));
   endtask

   initial begin
      logic [DW-1:0] ra, rb, rq, rr, rm;
      int            done_cnt, done1_k, sel;

      vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 16'b0000000000001110, 17, 16};
      vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 16'hFFFF,             17, 16};
      vecs[2] = '{16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 16'h0000,             17, 16};
      vecs[3] = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1, 16'h0000,             1,  0};
      vecs[4] = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 16'h0000,             17, 16};
      vecs[5] = '{16'd200,   16'd10,     16'd20,     16'd0,      1'b0, 16'd20,               17, 16};
      vecs[6] = '{16'd50,    16'd3,      16'd16,     16'd2,      1'b0, 16'd16,               17, 16};
      vecs[7] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 16'd1,                17, 16};
      vecs[8] = '{16'h8000,  16'hC000,   16'd0,      16'h8000,   1'b0, 16'd0,                17, 16};
      vecs[9] = '{16'hFFFE,  16'h8001,   16'd1,      16'h7FFD,   1'b0, 16'd1,                17, 16};

      rst_n      = 1'b0;
      i_start    = 1'b0;
      i_dividend = '0;
      i_divisor  = '0;
      #12;
      check("reset_outputs",
            32'({o_ready, o_enable, o_flag, o_msb, o_done, o_div_zero}), 32'b100000);
      check("reset_quot", 32'(o_quotation), 32'd0);
      check("reset_rem", 32'(o_remainder), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of an iteration run aborts it.
      @(negedge clk);
      i_dividend = 16'hFFFF;
      i_divisor  = 16'd1;
      i_start    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      check("midrst_partial_quot", 32'(o_quotation), 32'h1F);
      check("midrst_enable_before", 32'(o_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 32'({o_ready, o_enable, o_done, o_div_zero}), 32'b1000);
      check("midrst_quot", 32'(o_quotation), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_no_done", 32'({o_done, o_enable}), 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("postrst_idle", 32'({o_ready, o_done, o_enable}), 32'b100);
      end

      for (int i = 0; i < 10; i++) begin
         ref_div(vecs[i].a, vecs[i].b, rq, rr, rm);
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                 vecs[i].z, vecs[i].flags, rm, vecs[i].lat, vecs[i].en, 1'b1);
      end

      // Start held high: 200/10, then 50/3 presented during DONE must wait for IDLE.
      @(negedge clk);
      i_dividend = 16'd200;
      i_divisor  = 16'd10;
      i_start    = 1'b1;
      done_cnt   = 0;
      done1_k    = -10;
      for (int k = 1; k <= 60 && done_cnt < 2; k++) begin
         @(negedge clk);
         if (k == done1_k + 1)
            check("held_idle_after_done", 32'({o_ready, o_enable}), 32'b10);
         if (k == done1_k + 2)
            check("held_second_accept", 32'(o_enable), 32'd1);
         if (o_done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done1_k = k;
               check("held1_pos", 32'(k), 32'd17);
               check("held1_quot", 32'(o_quotation), 32'd20);
               check("held1_rem", 32'(o_remainder), 32'd0);
               i_dividend = 16'd50;
               i_divisor  = 16'd3;
            end else begin
               check("held2_pos", 32'(k), 32'd35);
               check("held2_quot", 32'(o_quotation), 32'd16);
               check("held2_rem", 32'(o_remainder), 32'd2);
            end
         end
      end
      check("held_done_count", 32'(done_cnt), 32'd2);
      i_start = 1'b0;
      for (int k = 0; k < 20; k++) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         ra  = DW'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0)     rb = '0;
         else if (sel < 5) rb = DW'($urandom_range(1, 255));
         else              rb = DW'($urandom);
         ref_div(ra, rb, rq, rr, rm);
         run_div($sformatf("rnd%0d", i), ra, rb, rq, rr, rb == '0,
                 (rb == '0) ? '0 : rq, rm, (rb == '0) ? 1 : 17, (rb == '0) ? 0 : 16, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
